// File: rtl/ex_divider_if.sv
// ex_divider_if
// Handshake and data bundle between the EX stage and the iterative divider.
// The master side (EX stage) drives the operation request and flush.
// The slave side (divider) returns the stall request, status and result.
//   start     : EX holds a valid divide op this cycle
//   op        : 00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
//   src1/src2 : dividend / divisor after operand forwarding
//   flush     : kill any in-flight operation
//   stall_req : freeze IF/ID/EX while the divide is outstanding
//   busy      : iteration in progress
//   done      : one-cycle pulse, result valid
//   result    : quotient or remainder
interface ex_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, src1, src2, flush,
    input  stall_req, busy, done, result
  );

  modport slave (
    input  start, op, src1, src2, flush,
    output stall_req, busy, done, result
  );
endinterface

// File: rtl/ex_divider.sv
// ex_divider
// Radix-2 restoring divider for div.w / mod.w / div.wu / mod.wu. Fixed
// latency of 33 cycles from the accepting cycle to the done pulse.
// Signed operands are converted to magnitudes on accept; the sign is
// restored on the way into the result register.
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous, active-high
//   dif   : ex_divider_if slave modport (request, flush, stall, result)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; result holds the last value
// S_CALC | one quotient bit per cycle, counter 0..31
// S_DONE | done pulse, result valid; a new start is accepted here too
module ex_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic         clk,
  input logic         reset,
  ex_divider_if.slave dif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] src1_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             divzero_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             is_signed;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quot_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] fin;

  // A start in DONE is treated exactly like one in IDLE; CALC ignores it.
  assign accept    = dif.start & ~dif.flush & (state_q != S_CALC);
  assign is_signed = ~dif.op[1];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: begin
        if (dif.flush)
          state_d = S_IDLE;
        else if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = S_DONE;
      end
      S_DONE: state_d = accept ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: operand magnitudes, one restoring step, sign fix-up.
  always_comb begin
    abs1 = (is_signed && dif.src1[WIDTH-1]) ? -dif.src1 : dif.src1;
    abs2 = (is_signed && dif.src2[WIDTH-1]) ? -dif.src2 : dif.src2;

    // Partial remainder is always below the divisor, so its MSB is spare.
    shifted = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_q};
    if (!trial[WIDTH]) begin
      rem_step  = trial;
      quot_step = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = shifted;
      quot_step = {quot_q[WIDTH-2:0], 1'b0};
    end

    q_fix = qneg_q ? -quot_step : quot_step;
    r_fix = rneg_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

    // Divide by zero bypasses the fix-up: all-ones quotient, raw dividend.
    if (divzero_q)
      fin = op_q[0] ? src1_q : '1;
    else
      fin = op_q[0] ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      src1_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      divzero_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= dif.op;
        rem_q     <= '0;
        quot_q    <= abs1;
        divisor_q <= abs2;
        src1_q    <= dif.src1;
        qneg_q    <= is_signed & (dif.src1[WIDTH-1] ^ dif.src2[WIDTH-1]);
        rneg_q    <= is_signed & dif.src1[WIDTH-1];
        divzero_q <= (dif.src2 == '0);
        cnt_q     <= '0;
      end else if (state_q == S_CALC && !dif.flush) begin
        rem_q  <= rem_step;
        quot_q <= quot_step;
        cnt_q  <= cnt_q + CNT_W'(1);
      end

      // The final iteration feeds the result register directly.
      if (state_q == S_CALC && state_d == S_DONE)
        result_q <= fin;

      busy_q <= (state_d == S_CALC);
      done_q <= (state_d == S_DONE);
    end
  end

  assign dif.stall_req = (dif.start & (state_q == S_IDLE) & ~dif.flush) |
                         (state_q == S_CALC);
  assign dif.busy      = busy_q;
  assign dif.done      = done_q;
  assign dif.result    = result_q;

endmodule
